// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit for a MIPS-style pipeline.
// 32-cycle shift-add multiply and restoring divide with MTHI/MTLO access.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  funct_q, funct_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        valid_op;
    logic        in_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_trial;
    logic [63:0] div_nxt;
    logic [63:0] acc_nxt;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Decode the request and form operand magnitudes for signed ops
    always_comb begin
        valid_op = start && (funct[5:2] == 4'b0110);
        in_div   = funct[1];
        a_neg    = !funct[0] && operand_a[31];
        b_neg    = !funct[0] && operand_b[31];
        a_mag    = a_neg ? (32'd0 - operand_a) : operand_a;
        b_mag    = b_neg ? (32'd0 - operand_b) : operand_b;
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]}
                  + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_nxt   = {mul_sum, acc_q[31:1]};
        div_trial = acc_q[63:31] - {1'b0, opnd_q};
        if (!div_trial[32])
            div_nxt = {div_trial[31:0], acc_q[30:0], 1'b1};
        else
            div_nxt = {acc_q[62:0], 1'b0};
        acc_nxt = funct_q[1] ? div_nxt : mul_nxt;
    end

    // Apply result signs to the final iteration's accumulator
    always_comb begin
        prod = (neg_q && !funct_q[0]) ? (64'd0 - acc_nxt) : acc_nxt;
        quot = (neg_q && !funct_q[0]) ? (32'd0 - acc_nxt[31:0])
                                      : acc_nxt[31:0];
        rem  = (rneg_q && !funct_q[0]) ? (32'd0 - acc_nxt[63:32])
                                       : acc_nxt[63:32];
        res_hi = funct_q[1] ? rem  : prod[63:32];
        res_lo = funct_q[1] ? quot : prod[31:0];
    end

    // Freeze upstream while a request is being accepted or iterating
    always_comb begin
        if (rst)
            stall_req = valid_op;
        else
            stall_req = ((state_q == IDLE) && valid_op)
                      || (state_q == BUSY);
    end

    // FSM and datapath next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        funct_d = funct_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_op && !flush) begin
                    funct_d = funct[1:0];
                    cnt_d   = 5'd0;
                    neg_d   = a_neg ^ b_neg;
                    if (in_div) begin
                        rneg_d = a_neg;
                        opnd_d = b_mag;
                        acc_d  = {32'd0, a_mag};
                        if (operand_b == 32'd0) begin
                            state_d = DONE;
                            hi_d    = operand_a;
                            lo_d    = 32'hFFFF_FFFF;
                            done_d  = 1'b1;
                        end else begin
                            state_d = BUSY;
                        end
                    end else begin
                        rneg_d  = 1'b0;
                        opnd_d  = a_mag;
                        acc_d   = {32'd0, b_mag};
                        state_d = BUSY;
                    end
                end else if (!valid_op) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            funct_q <= 2'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            opnd_q  <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            funct_q <= funct_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and random checks of muldiv_ctrl.
// Expected HI/LO values are queued on issue and popped on done.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    muldiv_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct     (funct),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} for one operation
    function automatic logic [63:0] model(input logic [5:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] uq;
        logic [63:0] ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            6'h18: return sa * sb;
            6'h19: return ua * ub;
            6'h1A: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Issue one op, track latency/stall, compare HI/LO on done.
    // wem=1: lo_we with the start; wem=2: lo_we in a BUSY cycle.
    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int lat,
                          input int wem);
        logic [63:0] r;
        logic [31:0] lo_prev;
        int n;
        int stc;
        bit got;
        lo_prev = lo;
        exp_q.push_back(e);
        start = 1'b1;
        funct = f;
        operand_a = a;
        operand_b = b;
        lo_we = (wem == 1);
        wdata = 32'hA5A5_A5A5;
        #1;
        n = 0;
        stc = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            if (stall_req) stc++;
            step();
            start = 1'b0;
            lo_we = 1'b0;
            operand_a = $urandom;
            operand_b = $urandom;
            n++;
            if (wem == 2 && n == 5) lo_we = 1'b1;
            #1;
            if (wem != 0 && n == 6)
                chk({tag, "_lo_hold"}, 64'(lo), 64'(lo_prev));
            if (done) got = 1'b1;
        end
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_stall"}, 64'(stc), 64'(lat));
        r = exp_q.pop_front();
        chk({tag, "_hi"}, 64'(hi), 64'(r[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(r[31:0]));
        step();
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    // Preload HI/LO, start MULTU, abort in BUSY cycle 10
    task automatic abort_test(input string tag, input bit use_rst);
        int dn;
        logic [31:0] e;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555_5555;
        step();
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk({tag, "_pre_hi"}, 64'(hi), 64'h5555_5555);
        chk({tag, "_pre_lo"}, 64'(lo), 64'h5555_5555);
        start = 1'b1;
        funct = 6'h19;
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        dn = 0;
        for (int k = 1; k < 45; k++) begin
            flush = (!use_rst && k == 10);
            rst = (use_rst && k == 10);
            #1;
            if (done) dn++;
            step();
        end
        flush = 1'b0;
        rst = 1'b0;
        #1;
        e = use_rst ? 32'd0 : 32'h5555_5555;
        chk({tag, "_hi"}, 64'(hi), 64'(e));
        chk({tag, "_lo"}, 64'(lo), 64'(e));
        chk({tag, "_no_done"}, 64'(dn), 64'd0);
        chk({tag, "_idle"}, 64'(stall_req), 64'd0);
    endtask

    initial begin
        int dn;
        logic [5:0] f;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b1;
        start = 1'b0;
        funct = 6'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        step();
        step();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);

        // Valid start during reset: stall is combinational, no accept
        start = 1'b1;
        funct = 6'h18;
        operand_b = 32'd3;
        #1;
        chk("rst_stall_start", 64'(stall_req), 64'd1);
        step();
        start = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_no_accept", 64'(stall_req), 64'd0);
        step();

        abort_test("flush", 1'b0);
        abort_test("rstbusy", 1'b1);

        run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 33, 2);
        run_op("mult_neg", 6'h18, 32'hFFFF_FFFE, 32'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 33, 1);
        run_op("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_op("divu", 6'h1B, 32'd100, 32'd7,
               64'h0000_0002_0000_000E, 33, 0);
        run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 33, 0);
        run_op("divu_zero", 6'h1B, 32'h0000_1234, 32'd0,
               64'h0000_1234_FFFF_FFFF, 1, 0);
        run_op("div_zero", 6'h1A, 32'hFFFF_FF00, 32'd0,
               64'hFFFF_FF00_FFFF_FFFF, 1, 0);

        for (int i = 0; i < 8; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 5) ? 32'd0 : $urandom;
            if (i == 2) b = b >> 20;
            run_op($sformatf("rand%0d", i), f, a, b, model(f, a, b),
                   (f[1] && b == 32'd0) ? 1 : 33, 0);
        end

        // Non-operation funct: ignored, so the MTLO goes through
        start = 1'b1;
        funct = 6'h20;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        #1;
        chk("bad_funct_stall", 64'(stall_req), 64'd0);
        step();
        start = 1'b0;
        lo_we = 1'b0;
        chk("bad_funct_mtlo", 64'(lo), 64'hCAFE_F00D);

        // Flush in IDLE blocks acceptance of a valid start
        start = 1'b1;
        funct = 6'h1B;
        operand_a = 32'd5;
        operand_b = 32'd0;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dn++;
            step();
        end
        chk("flush_idle_no_done", 64'(dn), 64'd0);
        chk("flush_idle_lo", 64'(lo), 64'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits and the iteration count at 32.
REQ-002 The block SHALL have the following ports, one per line, with clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue request from ID/EX stage.
- funct  in  6  operation: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU; any other value is not an operation.
- operand_a  in  32  rs value (multiplicand / dividend).
- operand_b  in  32  rt value (multiplier / divisor).
- flush  in  1  pipeline flush; aborts an operation in progress.
- hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
- wdata  in  32  MTHI/MTLO data.
- stall_req  out  1  asks the pipeline controller to freeze upstream stages.
- done  out  1  one-cycle pulse when hi/lo take a new mul/div result.
- hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-004 IDLE -> BUSY SHALL occur when start=1 and funct is one of 0x18..0x1B; start with any other funct SHALL be ignored.
REQ-005 On acceptance, the block SHALL latch the funct, the operand magnitudes (two's-complement absolute values for MULT/DIV, raw values for MULTU/DIVU) and the result signs, and SHALL clear a 5-bit iteration counter.
REQ-006 BUSY SHALL perform one iteration per cycle: shift-add for multiply, restoring subtract-shift for divide.
REQ-007 The counter SHALL increment each BUSY cycle; after iteration 31 the FSM SHALL go to DONE, so BUSY lasts exactly 32 cycles.
REQ-008 On the DONE-entry edge, hi/lo SHALL be written and done SHALL be 1 for the DONE cycle only; DONE -> IDLE SHALL be unconditional.
REQ-009 Multiply results SHALL be hi = product[63:32] and lo = product[31:0]; for MULT the 64-bit product SHALL be negated when the operand signs differ.
REQ-010 Divide results SHALL be lo = quotient and hi = remainder.
REQ-011 For signed divide, the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL be sign(a).
REQ-012 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-013 Divide by zero (operand_b = 0, DIV or DIVU) SHALL skip BUSY (IDLE -> DONE directly) and give lo = 0xFFFFFFFF and hi = operand_a.
REQ-014 stall_req SHALL be 1 combinationally in IDLE when a valid start is present, and in BUSY; it SHALL be 0 in DONE and otherwise.
REQ-015 flush=1 in BUSY SHALL return the FSM to IDLE on that edge, leave hi/lo unchanged and not pulse done; in DONE the result SHALL still commit.
REQ-016 flush=1 in IDLE together with start SHALL block acceptance.
REQ-017 hi_we/lo_we SHALL write wdata to hi/lo in IDLE only, and only when no valid start is present in the same cycle; they SHALL be ignored in BUSY and DONE.
REQ-018 Operand inputs SHALL be don't-care after acceptance; changes during BUSY SHALL NOT affect the result.

Reset
REQ-019 rst=1 SHALL force IDLE with hi=0, lo=0, done=0, counter=0 and all latched state cleared on the next edge.
REQ-020 stall_req SHALL be 0 during reset unless a valid start is present combinationally.
REQ-021 rst SHALL take priority over flush, start and the write strobes.
REQ-022 rst asserted mid-BUSY SHALL abort the operation with no done pulse.

Verification
REQ-023 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> stall_req high for 33 cycles, done on cycle 33 after acceptance, hi=0xFFFFFFFE, lo=0x00000001.
REQ-024 MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-025 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
REQ-026 DIVU a=0x1234, b=0 -> done one cycle after acceptance, lo=0xFFFFFFFF, hi=0x1234, no BUSY cycles.
REQ-027 Start MULTU with hi=lo=0x55555555 preloaded via MTHI/MTLO, then assert flush in BUSY cycle 10 -> FSM in IDLE, no done, hi/lo still 0x55555555; issue the same with rst in cycle 10 -> hi=lo=0.
REQ-028 lo_we=1 with wdata=0xA5A5A5A5 during BUSY -> lo ignored; lo_we together with a valid start in IDLE -> write dropped and the operation accepted.
